// File: rtl/user_wrapper_route_rd_if.sv
// rtl/user_wrapper_route_rd_if.sv - read stream bundle (tdata/tkeep/tlast/tid/tvalid/tready)
interface user_wrapper_route_rd_if #(
    parameter int DATA_BITS = 32,
    parameter int ID_BITS   = 4
) ();
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic [ID_BITS-1:0]     tid;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, tkeep, tlast, tid, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tid, tvalid, output tready);
endinterface

// File: rtl/user_wrapper_route_rd.sv
// rtl/user_wrapper_route_rd.sv - command-driven gate that routes one read packet at a time to a mux port
module user_wrapper_route_rd #(
    parameter int N_DESTS       = 4,
    parameter int CMD_DEPTH     = 4,
    parameter int AXI_DATA_BITS = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          s_cmd_valid,
    output logic                          s_cmd_ready,
    input  logic [1:0]                    s_cmd_dest,
    input  logic [15:0]                   s_cmd_len,
    user_wrapper_route_rd_if.slave        s_axis,
    user_wrapper_route_rd_if.master       m_axis,
    output logic [1:0]                    port_out,
    output logic                          busy,
    output logic                          err_len
);
    localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE   = 1;
    localparam logic [2:0]  N_DESTS_L = 3'(N_DESTS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FWD  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [1:0]  port_q, port_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        rdy_en_q, rdy_en_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [17:0] mem_q [CMD_DEPTH];
    logic [17:0] mem_d [CMD_DEPTH];

    logic        full, empty, push, fwd, beat, last_cnt, final_beat, dest_ok;
    logic [1:0]  head_dest;
    logic [15:0] head_len;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // Ready is held low until the first edge after reset release.
    assign s_cmd_ready = rdy_en_q && !full;
    assign push      = s_cmd_valid && s_cmd_ready;
    assign head_dest = mem_q[rd_q[AW-1:0]][17:16];
    assign head_len  = mem_q[rd_q[AW-1:0]][15:0];
    assign dest_ok   = ({1'b0, head_dest} < N_DESTS_L);

    assign fwd        = (state_q == ST_FWD);
    assign last_cnt   = (cnt_q == 16'd1);
    assign beat       = fwd && s_axis.tvalid && m_axis.tready;
    assign final_beat = beat && (last_cnt || s_axis.tlast);

    assign m_axis.tvalid = fwd && s_axis.tvalid;
    assign s_axis.tready = fwd && m_axis.tready;
    assign m_axis.tlast  = fwd && (last_cnt || s_axis.tlast);
    assign m_axis.tdata  = s_axis.tdata[AXI_DATA_BITS-1:0];
    assign m_axis.tkeep  = s_axis.tkeep[AXI_DATA_BITS/8-1:0];
    assign m_axis.tid    = s_axis.tid;

    assign port_out = port_q;
    assign busy     = fwd;
    assign err_len  = err_q;

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        rdy_en_d = 1'b1;
        wr_d     = wr_q;
        rd_d     = rd_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = {s_cmd_dest, s_cmd_len};
            wr_d = wr_q + PTR_ONE;
        end
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    rd_d = rd_q + PTR_ONE;
                    if ((head_len != 16'd0) && dest_ok) begin
                        port_d  = head_dest;
                        cnt_d   = head_len;
                        state_d = ST_FWD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FWD: begin
                if (beat) begin
                    cnt_d = cnt_q - 16'd1;
                    if (final_beat) begin
                        state_d = ST_IDLE;
                        // Length and source tlast must agree on the final beat.
                        err_d   = last_cnt ^ s_axis.tlast;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            port_q   <= 2'd0;
            cnt_q    <= 16'd0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdy_en_q <= rdy_en_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end
endmodule

// File: tb/tb_user_wrapper_route_rd.sv
// tb/tb_user_wrapper_route_rd.sv - self-checking bench for user_wrapper_route_rd
module tb_user_wrapper_route_rd;
    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        s_cmd_valid = 1'b0;
    logic        s_cmd_ready;
    logic [1:0]  s_cmd_dest = 2'd0;
    logic [15:0] s_cmd_len = 16'd0;
    logic [1:0]  port_out;
    logic        busy;
    logic        err_len;
    int          total = 0;
    int          bad = 0;

    user_wrapper_route_rd_if #(.DATA_BITS(32), .ID_BITS(4)) s_axis ();
    user_wrapper_route_rd_if #(.DATA_BITS(32), .ID_BITS(4)) m_axis ();

    user_wrapper_route_rd #(.N_DESTS(4), .CMD_DEPTH(DEPTH), .AXI_DATA_BITS(32)) dut (
        .aclk(aclk), .areset(areset),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_dest(s_cmd_dest), .s_cmd_len(s_cmd_len),
        .s_axis(s_axis), .m_axis(m_axis),
        .port_out(port_out), .busy(busy), .err_len(err_len)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_stream();
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tid    = '0;
        m_axis.tready = 1'b0;
    endtask

    task automatic push_cmd(input logic [1:0] dest, input int len);
        int n = 0;
        s_cmd_valid = 1'b1;
        s_cmd_dest  = dest;
        s_cmd_len   = 16'(len);
        #1;
        while (s_cmd_ready !== 1'b1 && n < 50) begin step(); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL push_timeout ready=%b required=1", s_cmd_ready); end
        step();
        s_cmd_valid = 1'b0;
    endtask

    // Expected behaviour from the packet rules: the packet ends at the first of
    // beat len or the source tlast beat; err_len unless both coincide.
    task automatic stream_pkt(input logic [1:0] dest, input int len, input int tpos);
        int done = 0;
        int budget = 0;
        int exp_beats;
        logic exp_last;
        logic exp_err;
        exp_beats = (tpos >= 1 && tpos < len) ? tpos : len;
        exp_err   = (tpos != len);
        total++;
        if (busy !== 1'b1 || port_out !== dest) begin
            bad++; $display("FAIL fwd_entry busy=%b port=%0d required busy=1 port=%0d", busy, port_out, dest);
        end
        while (done < exp_beats && budget < 300) begin
            s_axis.tvalid = ($urandom_range(0, 3) != 0);
            m_axis.tready = ($urandom_range(0, 3) != 0);
            s_axis.tdata  = $urandom;
            s_axis.tkeep  = 4'($urandom);
            s_axis.tid    = 4'($urandom);
            s_axis.tlast  = (done + 1 == tpos);
            #1;
            exp_last = (len - done == 1) || (done + 1 == tpos);
            total++;
            if (m_axis.tvalid !== s_axis.tvalid || s_axis.tready !== m_axis.tready) begin
                bad++; $display("FAIL handshake m_tvalid=%b s_tready=%b required %b %b", m_axis.tvalid, s_axis.tready, s_axis.tvalid, m_axis.tready);
            end
            total++;
            if (m_axis.tdata !== s_axis.tdata || m_axis.tkeep !== s_axis.tkeep || m_axis.tid !== s_axis.tid) begin
                bad++; $display("FAIL passthrough data=%h required %h", m_axis.tdata, s_axis.tdata);
            end
            total++;
            if (m_axis.tlast !== exp_last) begin
                bad++; $display("FAIL tlast beat=%0d got=%b required=%b", done + 1, m_axis.tlast, exp_last);
            end
            total++;
            if (port_out !== dest || busy !== 1'b1 || err_len !== 1'b0) begin
                bad++; $display("FAIL fwd_hold port=%0d busy=%b err=%b required port=%0d busy=1 err=0", port_out, busy, err_len, dest);
            end
            if (s_axis.tvalid && m_axis.tready) done++;
            step();
            budget++;
        end
        idle_stream();
        total++;
        if (budget >= 300) begin bad++; $display("FAIL stream_timeout beats=%0d required=%0d", done, exp_beats); end
        #1;
        total++;
        if (busy !== 1'b0 || m_axis.tvalid !== 1'b0 || s_axis.tready !== 1'b0) begin
            bad++; $display("FAIL bubble busy=%b m_tvalid=%b s_tready=%b required 0 0 0", busy, m_axis.tvalid, s_axis.tready);
        end
        total++;
        if (err_len !== exp_err) begin
            bad++; $display("FAIL err_len_end got=%b required=%b len=%0d tpos=%0d", err_len, exp_err, len, tpos);
        end
    endtask

    task automatic run_pkt(input logic [1:0] dest, input int len, input int tpos);
        push_cmd(dest, len);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL latency_t1 busy=%b required=0", busy); end
        step();
        stream_pkt(dest, len, tpos);
    endtask

    task automatic test_reset();
        idle_stream();
        areset = 1'b1;
        step(); step();
        total++;
        if (busy !== 1'b0 || port_out !== 2'd0 || err_len !== 1'b0 || s_cmd_ready !== 1'b0 ||
            m_axis.tvalid !== 1'b0 || s_axis.tready !== 1'b0) begin
            bad++; $display("FAIL reset_state busy=%b port=%0d err=%b rdy=%b required all 0", busy, port_out, err_len, s_cmd_ready);
        end
        areset = 1'b0;
        #1;
        total++;
        if (s_cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b required=0", s_cmd_ready); end
        step();
        total++;
        if (s_cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b required=1", s_cmd_ready); end
    endtask

    task automatic test_bad_cmd();
        s_cmd_valid = 1'b1; s_cmd_dest = 2'd3; s_cmd_len = 16'd0;
        #1; step();
        s_cmd_dest = 2'd1; s_cmd_len = 16'd1;
        step();
        s_cmd_valid = 1'b0;
        #1;
        total++;
        if (err_len !== 1'b1 || port_out !== 2'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL bad_cmd err=%b port=%0d busy=%b required 1 0 0", err_len, port_out, busy);
        end
        step();
        stream_pkt(2'd1, 1, 1);
    endtask

    task automatic test_fill();
        logic [1:0] dests [DEPTH+1];
        int         lens  [DEPTH+1];
        for (int i = 0; i <= DEPTH; i++) begin
            dests[i] = 2'($urandom);
            lens[i]  = $urandom_range(1, 4);
            s_cmd_valid = 1'b1; s_cmd_dest = dests[i]; s_cmd_len = 16'(lens[i]);
            #1;
            total++;
            if (s_cmd_ready !== 1'b1) begin bad++; $display("FAIL fill_ready idx=%0d got=%b required=1", i, s_cmd_ready); end
            step();
        end
        // Offer one more command while full; it must be refused.
        s_cmd_dest = 2'd3; s_cmd_len = 16'd7;
        #1;
        total++;
        if (s_cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b required=0", s_cmd_ready); end
        step();
        s_cmd_valid = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            stream_pkt(dests[i], lens[i], lens[i]);
            step();
        end
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL extra_packet busy=%b required=0", busy); end
    endtask

    task automatic test_reset_mid();
        push_cmd(2'd2, 5);
        step();
        s_axis.tvalid = 1'b1; m_axis.tready = 1'b1; s_axis.tlast = 1'b0;
        step();
        areset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || port_out !== 2'd0 || err_len !== 1'b0 || s_cmd_ready !== 1'b0 ||
            m_axis.tvalid !== 1'b0 || s_axis.tready !== 1'b0 || m_axis.tlast !== 1'b0) begin
            bad++; $display("FAIL async_reset busy=%b port=%0d rdy=%b m_tvalid=%b tlast=%b required all 0", busy, port_out, s_cmd_ready, m_axis.tvalid, m_axis.tlast);
        end
        #2;
        areset = 1'b0;
        idle_stream();
        step();
        total++;
        if (s_cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset rdy=%b busy=%b required 1 0", s_cmd_ready, busy);
        end
        run_pkt(2'd3, 2, 2);
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int len;
            len = $urandom_range(1, 6);
            run_pkt(2'($urandom), len, $urandom_range(0, len + 1));
            step();
        end
    endtask

    initial begin
        test_reset();
        test_bad_cmd();
        step();
        run_pkt(2'd2, 3, 3);
        step();
        run_pkt(2'd1, 4, 2);
        step();
        run_pkt(2'd0, 2, 0);
        step();
        test_fill();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/user_wrapper_route_rd.md
USER_WRAPPER_ROUTE_RD -- requirements
Module: user_wrapper_route_rd

Interface
REQ-001 Parameter N_DESTS, default 4: number of read-mux destinations; legal range 1..4.
REQ-002 Parameter CMD_DEPTH, default 4: route-command FIFO depth; power of two, 2..16.
REQ-003 aclk  input  1  sole clock; all logic on rising edge.
REQ-004 areset  input  1  asynchronous, active-high reset.
REQ-005 s_cmd_valid  input  1  route command valid.
REQ-006 s_cmd_ready  output  1  route command accepted when valid and ready are both high.
REQ-007 s_cmd_dest  input  2  destination port index for one packet.
REQ-008 s_cmd_len  input  16  packet length in beats; 0 is illegal.
REQ-009 s_axis  AXI4SR slave  AXI_DATA_BITS  upstream read stream (tdata, tkeep, tlast, tid, tvalid, tready).
REQ-010 m_axis  AXI4SR master  AXI_DATA_BITS  gated stream toward the read mux.
REQ-011 port_out  output  2  registered mux select; drives the read mux select input.
REQ-012 busy  output  1  high while in FWD.
REQ-013 err_len  output  1  one-cycle pulse on a length violation.

Function
REQ-014 Command FIFO: s_cmd_ready = not full; a push stores {dest, len}; full blocks the push, with no overwrite.
REQ-015 FSM states are IDLE and FWD only.
REQ-016 IDLE with FIFO non-empty: pop the head. If len>0 and dest<N_DESTS, load port_out=dest and beat counter=len, and go to FWD next cycle.
REQ-017 IDLE pop with len=0 or dest>=N_DESTS: discard the command, pulse err_len, stay in IDLE, leave port_out unchanged.
REQ-018 Latency: command accepted at cycle t -> FWD and valid port_out at cycle t+2, provided the FIFO was empty and the FSM was IDLE.
REQ-019 In IDLE: m_axis.tvalid=0 and s_axis.tready=0.
REQ-020 In FWD: m_axis.tvalid=s_axis.tvalid, s_axis.tready=m_axis.tready, and tdata/tkeep/tid pass through combinationally.
REQ-021 A beat is a cycle in FWD with s_axis.tvalid and m_axis.tready both high; each beat decrements the counter.
REQ-022 m_axis.tlast = (counter==1) OR s_axis.tlast, qualified by FWD.
REQ-023 Final beat: a beat with counter==1 or s_axis.tlast=1 causes FWD->IDLE on the next cycle.
REQ-024 Early end (s_axis.tlast=1 with counter>1) and late end (counter==1 with s_axis.tlast=0) each pulse err_len in the cycle after the final beat.
REQ-025 A normal end (counter==1 and s_axis.tlast=1 together) gives no err_len.
REQ-026 port_out SHALL NOT change while in FWD.
REQ-027 Exactly one idle bubble cycle follows every packet before the next FWD.
REQ-028 A push and a pop in the same cycle are both honoured; FIFO occupancy stays unchanged.
REQ-029 The 16-bit counter never wraps: it is only decremented in FWD, where it is always >=1.

Reset
REQ-030 While areset is high: FSM=IDLE, FIFO empty, counter=0, port_out=0, busy=0, err_len=0, m_axis.tvalid=0, s_axis.tready=0, s_cmd_ready=0.
REQ-031 Assertion mid-packet abandons the packet immediately, with no tlast emitted.
REQ-032 After deassertion, s_cmd_ready rises on the first clock edge.

Verification
REQ-033 Push {dest=2, len=3}, then 3 beats with tlast on beat 3 and m_axis.tready=1 -> port_out=2 at t+2, three beats out, m_axis.tlast on beat 3, err_len never set, IDLE afterwards.
REQ-034 Push {1,4}, then source tlast on beat 2 -> m_axis.tlast on beat 2, err_len pulse the next cycle, then IDLE.
REQ-035 Push {0,2}, source tlast never asserted -> m_axis.tlast forced on beat 2, err_len pulse.
REQ-036 Push CMD_DEPTH+1 commands with no stream traffic -> s_cmd_ready low once full. Then stream all packets -> every dest is applied in order with one bubble between packets.
REQ-037 Push {3,0}, then {1,1} -> one err_len pulse with port_out held at 0, then packet to port 1.
REQ-038 Assert areset in the second beat of a {2,5} packet -> all outputs at reset values asynchronously. Next command proceeds normally.
